sdram_test_master: RTL

- Initiator for the SDRAM controller user port: sweeps an address range, writes a deterministic pattern, reads it back and compares.
- Sits in front of sdram_controller as its only requester for board bring-up and memory self-test.
- Reports pass/fail, a saturating error count and the first failing address.
- Also detects a hung controller via a response timeout.

---
 rtl/sdram_test_pkg.sv | 28 ++
 rtl/sdram_test_master_if.sv | 40 ++++
 rtl/sdram_test_pattern.sv | 27 ++
 rtl/sdram_test_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_test_pkg.sv
// rtl/sdram_test_pkg.sv - shared types and constants for the SDRAM test master
//
// Contents:
//   state_e              sweep sequencer states
//   ERROR_COUNT_WIDTH    width of the saturating mismatch counter
//   DEFAULT_PATTERN_SEED base value of the address-derived data pattern
//   sat_inc()            saturating increment for the mismatch counter
package sdram_test_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        FINISH  = 3'd5
    } state_e;

    localparam int          ERROR_COUNT_WIDTH    = 16;
    localparam logic [31:0] DEFAULT_PATTERN_SEED = 32'hA5A5_0000;

    function automatic logic [ERROR_COUNT_WIDTH-1:0] sat_inc(
        input logic [ERROR_COUNT_WIDTH-1:0] value
    );
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/sdram_test_master_if.sv
// rtl/sdram_test_master_if.sv - user-port bus between test master and SDRAM controller
//
// Signals:
//   request       one-cycle transaction strobe (master -> controller)
//   write_enable  1 = write, 0 = read; qualified by request
//   address       transaction address, stable until response
//   write_data    write payload, stable until response
//   response      one-cycle completion pulse (controller -> master)
//   read_data     read payload, valid in the response cycle of a read
interface sdram_test_master_if #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 32
) ();

    logic                     request;
    logic                     write_enable;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    write_data;
    logic                     response;
    logic [DATA_WIDTH-1:0]    read_data;

    modport master (
        output request,
        output write_enable,
        output address,
        output write_data,
        input  response,
        input  read_data
    );

    modport slave (
        input  request,
        input  write_enable,
        input  address,
        input  write_data,
        output response,
        output read_data
    );

endinterface

// File: rtl/sdram_test_pattern.sv
// rtl/sdram_test_pattern.sv - expected-data generator for the SDRAM sweep
//
// Ports:
//   seed     base value of the pattern
//   address  sweep address
//   invert   selects the bitwise-inverted pattern
//   data     seed + zero_extend(address), optionally inverted
module sdram_test_pattern
    import sdram_test_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 32
) (
    input  logic [DATA_WIDTH-1:0]    seed,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     invert,
    output logic [DATA_WIDTH-1:0]    data
);

    logic [DATA_WIDTH-1:0] base;

    always_comb begin
        base = seed + DATA_WIDTH'(address);
        data = invert ? ~base : base;
    end

endmodule

// File: rtl/sdram_test_master.sv
// rtl/sdram_test_master.sv - write/read-back memory self-test initiator for the SDRAM controller
//
// Optional feature macro: SDRAM_TEST_MASTER_INVERT_PASS_EN (adds a second sweep
// using the inverted pattern; errors accumulate across both sweeps).
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   start                one-cycle pulse, begins a test when idle
//   busy                 high while a test is in progress
//   done                 one-cycle pulse at test end
//   pass                 result, valid with done, held until next start
//   timeout              sticky: controller failed to respond in time
//   error_count          saturating mismatch count
//   first_error_address  address of the first mismatch, 0 if none
//   mem                  controller user port (master side)
module sdram_test_master
    import sdram_test_pkg::*;
#(
    parameter int          ADDRESS_WIDTH  = 13,
    parameter int          DATA_WIDTH     = 32,
    parameter int          START_ADDRESS  = 0,
    parameter int          END_ADDRESS    = 8191,
    parameter logic [31:0] PATTERN_SEED   = DEFAULT_PATTERN_SEED,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [ERROR_COUNT_WIDTH-1:0]  error_count,
    output logic [ADDRESS_WIDTH-1:0]      first_error_address,
    sdram_test_master_if.master           mem
);

    localparam int WAIT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDRESS_WIDTH-1:0] START_A   = ADDRESS_WIDTH'(START_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] END_A     = ADDRESS_WIDTH'(END_ADDRESS);
    localparam logic [WAIT_WIDTH-1:0]    WAIT_LAST = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0]    SEED_W    = DATA_WIDTH'(PATTERN_SEED);

    state_e                         state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]       cursor_q, cursor_d;
    logic [WAIT_WIDTH-1:0]          wait_cnt_q, wait_cnt_d;
    logic [ERROR_COUNT_WIDTH-1:0]   error_count_q, error_count_d;
    logic [ADDRESS_WIDTH-1:0]       first_error_address_q, first_error_address_d;
    logic                           timeout_q, timeout_d;
    logic                           pass_q, pass_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           request_q, request_d;
    logic                           write_enable_q, write_enable_d;
    logic [ADDRESS_WIDTH-1:0]       address_q, address_d;
    logic [DATA_WIDTH-1:0]          write_data_q, write_data_d;
    logic [DATA_WIDTH-1:0]          expected_q, expected_d;
    logic [DATA_WIDTH-1:0]          pattern_data;
    logic                           pattern_invert;
    logic                           at_end;
    logic                           wait_expired;

`ifdef SDRAM_TEST_MASTER_INVERT_PASS_EN
    logic                           invert_q, invert_d;
    assign pattern_invert = invert_d;
`else
    assign pattern_invert = 1'b0;
`endif

    assign at_end       = (cursor_q == END_A);
    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    // Driven from the next cursor so the pattern for a new address is ready
    // at the same edge that launches the write, and expected_q always tracks
    // the current cursor for the read compare.
    sdram_test_pattern #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_pattern (
        .seed    (SEED_W),
        .address (cursor_d),
        .invert  (pattern_invert),
        .data    (pattern_data)
    );

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q               <= IDLE;
            cursor_q              <= '0;
            wait_cnt_q            <= '0;
            error_count_q         <= '0;
            first_error_address_q <= '0;
            timeout_q             <= 1'b0;
            pass_q                <= 1'b0;
            busy_q                <= 1'b0;
            done_q                <= 1'b0;
            request_q             <= 1'b0;
            write_enable_q        <= 1'b0;
            address_q             <= '0;
            write_data_q          <= '0;
            expected_q            <= '0;
`ifdef SDRAM_TEST_MASTER_INVERT_PASS_EN
            invert_q              <= 1'b0;
`endif
        end else begin
            state_q               <= state_d;
            cursor_q              <= cursor_d;
            wait_cnt_q            <= wait_cnt_d;
            error_count_q         <= error_count_d;
            first_error_address_q <= first_error_address_d;
            timeout_q             <= timeout_d;
            pass_q                <= pass_d;
            busy_q                <= busy_d;
            done_q                <= done_d;
            request_q             <= request_d;
            write_enable_q        <= write_enable_d;
            address_q             <= address_d;
            write_data_q          <= write_data_d;
            expected_q            <= expected_d;
`ifdef SDRAM_TEST_MASTER_INVERT_PASS_EN
            invert_q              <= invert_d;
`endif
        end
    end

    // Next-state and sweep bookkeeping
    always_comb begin
        state_d               = state_q;
        cursor_d              = cursor_q;
        wait_cnt_d            = wait_cnt_q;
        error_count_d         = error_count_q;
        first_error_address_d = first_error_address_q;
        timeout_d             = timeout_q;
        pass_d                = pass_q;
`ifdef SDRAM_TEST_MASTER_INVERT_PASS_EN
        invert_d              = invert_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d               = WR_REQ;
                    cursor_d              = START_A;
                    error_count_d         = '0;
                    first_error_address_d = '0;
                    timeout_d             = 1'b0;
                    pass_d                = 1'b0;
`ifdef SDRAM_TEST_MASTER_INVERT_PASS_EN
                    invert_d              = 1'b0;
`endif
                end
            end
            WR_REQ: begin
                state_d    = WR_WAIT;
                wait_cnt_d = '0;
            end
            WR_WAIT: begin
                if (mem.response) begin
                    if (at_end) begin
                        cursor_d = START_A;
                        state_d  = RD_REQ;
                    end else begin
                        cursor_d = cursor_q + 1'b1;
                        state_d  = WR_REQ;
                    end
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RD_REQ: begin
                state_d    = RD_WAIT;
                wait_cnt_d = '0;
            end
            RD_WAIT: begin
                if (mem.response) begin
                    if (mem.read_data != expected_q) begin
                        error_count_d = sat_inc(error_count_q);
                        // A zero count means no mismatch yet in this test;
                        // once non-zero it can only grow or saturate.
                        if (error_count_q == '0) begin
                            first_error_address_d = cursor_q;
                        end
                    end
                    if (at_end) begin
`ifdef SDRAM_TEST_MASTER_INVERT_PASS_EN
                        if (!invert_q) begin
                            invert_d = 1'b1;
                            cursor_d = START_A;
                            state_d  = WR_REQ;
                        end else begin
                            state_d  = FINISH;
                        end
`else
                        state_d = FINISH;
`endif
                    end else begin
                        cursor_d = cursor_q + 1'b1;
                        state_d  = RD_REQ;
                    end
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result is latched on entry to FINISH using the final counts,
        // including a mismatch on the very last read.
        if ((state_d == FINISH) && (state_q != FINISH)) begin
            pass_d = (error_count_d == '0) && !timeout_d;
        end
    end

    // Registered outputs, decoded from the state being entered so they line
    // up with state_q in the following cycle.
    always_comb begin
        request_d      = (state_d == WR_REQ) || (state_d == RD_REQ);
        busy_d         = (state_d != IDLE) && (state_d != FINISH);
        done_d         = (state_d == FINISH);
        address_d      = request_d ? cursor_d : address_q;
        write_enable_d = write_enable_q;
        write_data_d   = write_data_q;
        expected_d     = pattern_data;
        if (state_d == WR_REQ) begin
            write_enable_d = 1'b1;
            write_data_d   = pattern_data;
        end else if (state_d == RD_REQ) begin
            write_enable_d = 1'b0;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign pass                = pass_q;
    assign timeout             = timeout_q;
    assign error_count         = error_count_q;
    assign first_error_address = first_error_address_q;

    assign mem.request      = request_q;
    assign mem.write_enable = write_enable_q;
    assign mem.address      = address_q;
    assign mem.write_data   = write_data_q;

endmodule
